// File: rtl/timer_bank_pkg.sv
// Shared register map, global-page select and CTRL field layout for the timer bank.
// Imported by the channel, the top level and the bench so offsets live in one place.
package timer_bank_pkg;

  localparam logic [1:0] REG_COUNT    = 2'd0;
  localparam logic [1:0] REG_COMPARE  = 2'd1;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;
  localparam logic [1:0] REG_PRESCALE = 2'd0;
  localparam logic [1:0] REG_PENDING  = 2'd1;

  localparam logic [3:0] GLOBAL_SEL = 4'hF;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  typedef struct packed {
    logic ie;
    logic ar;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/timer_bank_if.sv
// Register-access bus for the timer bank: write/read strobes, address, data.
// rdata is registered by the slave; the strobes never stall.
interface timer_bank_if #(
  parameter int WIDTH = 32
);
  logic             we;
  logic             re;
  logic [5:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  modport master (output we, output re, output addr, output wdata, input rdata);
  modport slave  (input we, input re, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_chan.sv
// One timer channel: COUNT/COMPARE/CTRL/FLAG with tick-driven compare-match.
// State updates on the edge after the strobe; no backpressure.
module timer_chan
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             cnt_we_i,
  input  logic             cmp_we_i,
  input  logic             ctrl_we_i,
  input  logic             w1c_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] compare_o,
  output logic [2:0]       ctrl_o,
  output logic             flag_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] compare_q, compare_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             flag_q, flag_d;

  // Priority order is deliberate: a match set beats W1C, a COUNT write
  // suppresses the tick entirely, and a CTRL write beats the one-shot clear.
  always_comb begin
    count_d   = count_q;
    compare_d = cmp_we_i ? wdata_i : compare_q;
    ctrl_d    = ctrl_q;
    flag_d    = flag_q;
    if (w1c_i) flag_d = 1'b0;
    if (cnt_we_i) begin
      count_d = wdata_i;
    end else if (tick_i && ctrl_q.en) begin
      if (count_q == compare_q) begin
        flag_d  = 1'b1;
        count_d = '0;
        if (!ctrl_q.ar) ctrl_d.en = 1'b0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
    if (ctrl_we_i) ctrl_d = ctrl_t'(wdata_i[2:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '1;
      ctrl_q    <= '0;
      flag_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      flag_q    <= flag_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ctrl_o    = ctrl_q;
  assign flag_o    = flag_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH compare-match timers sharing one prescaled tick; rdata one cycle after re.
// Prescaler present only with TIMER_BANK_PRESCALE_EN defined, else tick every cycle.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32,
  parameter int PS_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  timer_bank_if.slave     bus,
  output logic [N_CH-1:0] irq,
  output logic            irq_any
);

  logic [3:0]       ch_sel;
  logic [1:0]       reg_sel;
  logic             tick;
  logic [WIDTH-1:0] ps_rd;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] rdata_q;

  logic [WIDTH-1:0] count_w   [N_CH];
  logic [WIDTH-1:0] compare_w [N_CH];
  logic [2:0]       ctrl_w    [N_CH];
  logic [N_CH-1:0]  flag_w;

  assign ch_sel  = bus.addr[5:2];
  assign reg_sel = bus.addr[1:0];

`ifdef TIMER_BANK_PRESCALE_EN
  logic [PS_W-1:0] ps_q, ps_d, pcnt_q, pcnt_d;
  logic            ps_we;

  assign ps_we = bus.we && (ch_sel == GLOBAL_SEL) && (reg_sel == REG_PRESCALE);
  assign tick  = (pcnt_q == ps_q);
  assign ps_rd = WIDTH'(ps_q);

  // Writing PRESCALE restarts the phase so the first tick lands PRESCALE+1 cycles later.
  always_comb begin
    ps_d   = ps_we ? PS_W'(bus.wdata) : ps_q;
    pcnt_d = (ps_we || tick) ? '0 : pcnt_q + PS_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q   <= '0;
      pcnt_q <= '0;
    end else begin
      ps_q   <= ps_d;
      pcnt_q <= pcnt_d;
    end
  end
`else
  assign tick  = 1'b1;
  assign ps_rd = WIDTH'({PS_W{1'b0}});
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    logic hit;
    assign hit = bus.we && (ch_sel == 4'(i));

    timer_chan #(.WIDTH(WIDTH)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick),
      .cnt_we_i  (hit && (reg_sel == REG_COUNT)),
      .cmp_we_i  (hit && (reg_sel == REG_COMPARE)),
      .ctrl_we_i (hit && (reg_sel == REG_CTRL)),
      .w1c_i     (hit && (reg_sel == REG_STATUS) && bus.wdata[0]),
      .wdata_i   (bus.wdata),
      .count_o   (count_w[i]),
      .compare_o (compare_w[i]),
      .ctrl_o    (ctrl_w[i]),
      .flag_o    (flag_w[i])
    );

    assign irq[i] = flag_w[i] & ctrl_w[i][CTRL_IE];
  end

  assign irq_any = |irq;

  always_comb begin
    rd_val = '0;
    if (ch_sel == GLOBAL_SEL) begin
      case (reg_sel)
        REG_PRESCALE: rd_val = ps_rd;
        REG_PENDING:  rd_val = WIDTH'(flag_w);
        default:      rd_val = '0;
      endcase
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_sel == 4'(i)) begin
          case (reg_sel)
            REG_COUNT:   rd_val = count_w[i];
            REG_COMPARE: rd_val = compare_w[i];
            REG_CTRL:    rd_val = WIDTH'(ctrl_w[i]);
            default:     rd_val = WIDTH'(flag_w[i]);
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata_q <= '0;
    else if (bus.re) rdata_q <= rd_val;
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: reset, autoreload, one-shot, prescale, write collisions.
// Expected values are hand-derived from the register behaviour for N_CH=4, WIDTH=32.
module tb_timer_bank;
  import timer_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq;
  logic       irq_any;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  always #5 clk = ~clk;

  timer_bank_if #(.WIDTH(32)) bus ();

  timer_bank #(.N_CH(4), .WIDTH(32), .PS_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .irq     (irq),
    .irq_any (irq_any)
  );

  task automatic wr(input logic [3:0] ch, input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1; bus.addr = {ch, r}; bus.wdata = d;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] ch, input logic [1:0] r, output logic [31:0] d);
    @(negedge clk);
    bus.re = 1'b1; bus.addr = {ch, r};
    @(posedge clk); #1;
    bus.re = 1'b0;
    d = bus.rdata;
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.we = 1'b0; bus.re = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #1;
    total_cnt++; if (irq !== 4'b0 || irq_any !== 1'b0) $display("FAIL reset_irq: got %b/%b want 0000/0", irq, irq_any); else pass_cnt++;
    total_cnt++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.rdata); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    rd(4'd0, REG_COUNT, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL reset_count: got %h want 0", v); else pass_cnt++;
    rd(4'd2, REG_COMPARE, v);
    total_cnt++; if (v !== 32'hFFFF_FFFF) $display("FAIL reset_compare: got %h want ffffffff", v); else pass_cnt++;
    rd(4'd3, REG_CTRL, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", v); else pass_cnt++;
    rd(GLOBAL_SEL, REG_PRESCALE, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL reset_prescale: got %h want 0", v); else pass_cnt++;
    rd(GLOBAL_SEL, REG_PENDING, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL reset_pending: got %h want 0", v); else pass_cnt++;
    rd(4'd0, REG_COMPARE, v);
    rd(4'd5, REG_COMPARE, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL unmapped_chan: got %h want 0", v); else pass_cnt++;
    rd(GLOBAL_SEL, 2'd2, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL unmapped_global: got %h want 0", v); else pass_cnt++;
  endtask

  task automatic test_autoreload();
    logic [31:0] v;
    do_reset();
    wr(4'd0, REG_COMPARE, 32'd5);
    wr(4'd0, REG_CTRL, 32'h3);
    for (int k = 1; k <= 12; k++) begin
      rd(4'd0, REG_COUNT, v);
      total_cnt++;
      if (v !== 32'((k - 1) % 6)) $display("FAIL autoreload_count[%0d]: got %0d want %0d", k, v, (k - 1) % 6);
      else pass_cnt++;
    end
    rd(GLOBAL_SEL, REG_PENDING, v);
    total_cnt++; if (v !== 32'h1) $display("FAIL autoreload_pending: got %h want 1", v); else pass_cnt++;
    total_cnt++; if (irq !== 4'b0) $display("FAIL autoreload_no_ie: got %b want 0000", irq); else pass_cnt++;
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    wr(4'd1, REG_COMPARE, 32'd3);
    wr(4'd1, REG_CTRL, 32'h5);
    tick_n(3);
    total_cnt++; if (irq !== 4'b0) $display("FAIL oneshot_early: got %b want 0000", irq); else pass_cnt++;
    tick_n(1);
    total_cnt++; if (irq !== 4'b0010 || irq_any !== 1'b1) $display("FAIL oneshot_irq: got %b/%b want 0010/1", irq, irq_any); else pass_cnt++;
    rd(4'd1, REG_CTRL, v);
    total_cnt++; if (v !== 32'h4) $display("FAIL oneshot_ctrl: got %h want 4", v); else pass_cnt++;
    tick_n(3);
    rd(4'd1, REG_COUNT, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL oneshot_count: got %h want 0", v); else pass_cnt++;
    wr(4'd1, REG_STATUS, 32'h1);
    total_cnt++; if (irq !== 4'b0 || irq_any !== 1'b0) $display("FAIL oneshot_w1c: got %b/%b want 0000/0", irq, irq_any); else pass_cnt++;
  endtask

  task automatic test_prescale();
    logic [31:0] v;
    do_reset();
    wr(4'd2, REG_COMPARE, 32'd1);
    wr(GLOBAL_SEL, REG_PRESCALE, 32'd3);
    tick_n(3);
    wr(4'd2, REG_CTRL, 32'h7);
`ifdef TIMER_BANK_PRESCALE_EN
    tick_n(7);
    total_cnt++; if (irq !== 4'b0) $display("FAIL prescale_early: got %b want 0000", irq); else pass_cnt++;
    tick_n(1);
    total_cnt++; if (irq !== 4'b0100) $display("FAIL prescale_flag: got %b want 0100", irq); else pass_cnt++;
    rd(GLOBAL_SEL, REG_PRESCALE, v);
    total_cnt++; if (v !== 32'd3) $display("FAIL prescale_read: got %h want 3", v); else pass_cnt++;
`else
    tick_n(1);
    total_cnt++; if (irq !== 4'b0) $display("FAIL prescale_early: got %b want 0000", irq); else pass_cnt++;
    tick_n(1);
    total_cnt++; if (irq !== 4'b0100) $display("FAIL prescale_flag: got %b want 0100", irq); else pass_cnt++;
    rd(GLOBAL_SEL, REG_PRESCALE, v);
    total_cnt++; if (v !== 32'd0) $display("FAIL prescale_read: got %h want 0", v); else pass_cnt++;
`endif
  endtask

  task automatic test_count_write();
    logic [31:0] v;
    do_reset();
    wr(4'd3, REG_COMPARE, 32'd2);
    wr(4'd3, REG_CTRL, 32'h7);
    tick_n(2);
    wr(4'd3, REG_COUNT, 32'd2);
    total_cnt++; if (irq !== 4'b0) $display("FAIL cntwr_no_match: got %b want 0000", irq); else pass_cnt++;
    tick_n(1);
    total_cnt++; if (irq !== 4'b1000) $display("FAIL cntwr_next_tick: got %b want 1000", irq); else pass_cnt++;
    rd(4'd3, REG_COUNT, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL cntwr_count: got %h want 0", v); else pass_cnt++;
  endtask

  task automatic test_collisions();
    logic [31:0] v;
    do_reset();
    wr(4'd0, REG_COMPARE, 32'd2);
    wr(4'd0, REG_CTRL, 32'h7);
    tick_n(2);
    wr(4'd0, REG_STATUS, 32'h1);
    total_cnt++; if (irq !== 4'b0001) $display("FAIL w1c_vs_set: got %b want 0001", irq); else pass_cnt++;
    rd(GLOBAL_SEL, REG_PENDING, v);
    total_cnt++; if (v !== 32'h1) $display("FAIL w1c_pending: got %h want 1", v); else pass_cnt++;
    wr(4'd1, REG_COMPARE, 32'd1);
    wr(4'd1, REG_CTRL, 32'h5);
    tick_n(1);
    wr(4'd1, REG_CTRL, 32'h5);
    total_cnt++; if (irq !== 4'b0011) $display("FAIL ctrl_collide_irq: got %b want 0011", irq); else pass_cnt++;
    rd(4'd1, REG_CTRL, v);
    total_cnt++; if (v !== 32'h5) $display("FAIL ctrl_collide_en: got %h want 5", v); else pass_cnt++;
  endtask

  task automatic test_reset_midcount();
    logic [31:0] v;
    do_reset();
    wr(4'd1, REG_COMPARE, 32'd0);
    wr(4'd1, REG_CTRL, 32'h5);
    wr(4'd0, REG_COMPARE, 32'd10);
    wr(4'd0, REG_CTRL, 32'h7);
    for (int k = 1; k <= 7; k++) rd(4'd0, REG_COUNT, v);
    total_cnt++; if (v !== 32'd6) $display("FAIL midcnt_count: got %0d want 6", v); else pass_cnt++;
    total_cnt++; if (irq !== 4'b0010) $display("FAIL midcnt_pre_irq: got %b want 0010", irq); else pass_cnt++;
    #3 rst = 1'b1;
    #1;
    total_cnt++; if (irq !== 4'b0 || irq_any !== 1'b0) $display("FAIL midcnt_async_irq: got %b/%b want 0000/0", irq, irq_any); else pass_cnt++;
    total_cnt++; if (bus.rdata !== 32'h0) $display("FAIL midcnt_async_rdata: got %h want 0", bus.rdata); else pass_cnt++;
    @(negedge clk); #2 rst = 1'b0;
    tick_n(12);
    total_cnt++; if (irq !== 4'b0) $display("FAIL midcnt_no_flag: got %b want 0000", irq); else pass_cnt++;
    rd(4'd0, REG_COMPARE, v);
    total_cnt++; if (v !== 32'hFFFF_FFFF) $display("FAIL midcnt_compare: got %h want ffffffff", v); else pass_cnt++;
    rd(4'd0, REG_COUNT, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL midcnt_count_rst: got %h want 0", v); else pass_cnt++;
    rd(GLOBAL_SEL, REG_PENDING, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL midcnt_pending: got %h want 0", v); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed so far)", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_autoreload();
    test_oneshot();
    test_prescale();
    test_count_write();
    test_collisions();
    test_reset_midcount();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
